// File: rtl/uat_tx.sv
// uat_tx: universal asynchronous transmitter, the transmit end of the uar serial link.
// Frame: idle high, one start bit (0), DATA_BITS data bits LSB first, STOP_BITS stop bits (1),
// each bit held CLKS_PER_BIT clocks. All outputs come straight from flops.
// Optional feature macro: UAT_TX_HOLD_BUF_EN adds a one-entry holding register so a byte
// can be accepted while a frame is on the line and sent back-to-back with no idle gap.
// Parameter ranges: CLKS_PER_BIT 2..256, DATA_BITS 5..8, STOP_BITS 1..2.
module uat_tx #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 gl_reset,
    input  logic [DATA_BITS-1:0] dIn,
    input  logic                 load,
    output logic                 ready,
    output logic                 dOut,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned TICK_W = 8;
    localparam int unsigned BIT_W  = 4;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 accept;
    logic                 stop_end;

`ifdef UAT_TX_HOLD_BUF_EN
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
`endif

    // A byte is taken whenever the registered ready meets a load request.
    assign accept   = load & ready;

    // Last clock of the final stop bit: the frame ends on this edge.
    assign stop_end = (state == STOP) && (tick_cnt == TICK_LAST) && (bit_cnt == STOP_LAST);

    // Frame sequencer: state, counters, shifter and all registered outputs.
    always_ff @(posedge clk or posedge gl_reset) begin
        if (gl_reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            dOut     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
`ifdef UAT_TX_HOLD_BUF_EN
            hold      <= '0;
            hold_full <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift    <= dIn;
                        state    <= START;
                        dOut     <= 1'b0;
                        busy     <= 1'b1;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
`ifndef UAT_TX_HOLD_BUF_EN
                        ready    <= 1'b0;
`endif
                    end
                end

                START: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        state    <= DATA;
                        dOut     <= shift[0];
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end

                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                            dOut    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shift   <= shift >> 1;
                            dOut    <= shift[1];
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end

                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
`ifdef UAT_TX_HOLD_BUF_EN
                            // Pending byte goes straight into a new start bit.
                            if (hold_full) begin
                                shift <= hold;
                                state <= START;
                                dOut  <= 1'b0;
                            end else if (accept) begin
                                shift <= dIn;
                                state <= START;
                                dOut  <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
`else
                            state <= IDLE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if ((tick_cnt == TICK_PRE) && (bit_cnt == STOP_LAST)) begin
                            done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    dOut  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase

`ifdef UAT_TX_HOLD_BUF_EN
            // Holding register: filled by an accept during a frame, drained at frame end.
            if (accept && (state != IDLE) && !stop_end) begin
                hold      <= dIn;
                hold_full <= 1'b1;
                ready     <= 1'b0;
            end else if (stop_end && hold_full) begin
                hold_full <= 1'b0;
                ready     <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uat_tx.sv
// tb_uat_tx: directed bench for uat_tx with default parameters (8 clocks/bit, 8N1).
// Cycle k of a frame is the k-th clock period after the edge that accepted the byte.
module tb_uat_tx;

    localparam int CPB   = 8;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int FRAME = (1 + DB + SB) * CPB;

    logic       clk = 1'b0;
    logic       gl_reset;
    logic       load;
    logic [7:0] dIn;
    logic       ready;
    logic       dOut;
    logic       busy;
    logic       done;

    int compares = 0;
    int errors   = 0;

    uat_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .STOP_BITS   (SB)
    ) dut (
        .clk     (clk),
        .gl_reset(gl_reset),
        .dIn     (dIn),
        .load    (load),
        .ready   (ready),
        .dOut    (dOut),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Expected line level in cycle k of a frame carrying byte b.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        if (k <= CPB) return 1'b0;
        if (k <= CPB * (1 + DB)) return b[(k - CPB - 1) / CPB];
        return 1'b1;
    endfunction

    // Expected ready in cycle k; inject is the cycle a second byte is offered (0 = none).
    function automatic logic exp_ready(input int k, input int inject);
`ifdef UAT_TX_HOLD_BUF_EN
        return (inject == 0) || (k <= inject);
`else
        if (k < 0 || inject < 0) return 1'b1;
        return 1'b0;
`endif
    endfunction

    // Offer byte b as soon as ready is seen; leaves the bench just after the accept edge.
    task automatic send(input logic [7:0] b, input string tag);
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        compares++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s send_ready: got %b want 1 (timeout)", tag, ready);
        end
        dIn  = b;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        dIn  = 8'($urandom);
    endtask

    // Check every cycle of one frame; optionally offer byte b2 during cycle inject.
    task automatic check_frame(input logic [7:0] b, input int inject, input logic [7:0] b2,
                               input string tag);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            compares++;
            if (dOut !== exp_line(b, k)) begin
                errors++;
                $display("FAIL %s dOut cycle %0d: got %b want %b", tag, k, dOut, exp_line(b, k));
            end
            compares++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want 1", tag, k, busy);
            end
            compares++;
            if (done !== 1'(k == FRAME)) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b want %b", tag, k, done, 1'(k == FRAME));
            end
            compares++;
            if (ready !== exp_ready(k, inject)) begin
                errors++;
                $display("FAIL %s ready cycle %0d: got %b want %b", tag, k, ready, exp_ready(k, inject));
            end
            if (k == inject) begin
                dIn  = b2;
                load = 1'b1;
                @(posedge clk);
                #1;
                load = 1'b0;
            end
        end
    endtask

    // Line must stay idle for n cycles.
    task automatic check_idle(input int n, input string tag);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            compares++;
            if ({dOut, busy, ready, done} !== 4'b1010) begin
                errors++;
                $display("FAIL %s idle cycle %0d: got dOut/busy/ready/done=%b want 1010",
                         tag, k, {dOut, busy, ready, done});
            end
        end
    endtask

    task automatic test_reset();
        gl_reset = 1'b1;
        load     = 1'b0;
        dIn      = 8'h00;
        #1;
        compares++;
        if ({dOut, busy, ready, done} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_outputs: got dOut/busy/ready/done=%b want 1010",
                     {dOut, busy, ready, done});
        end
        repeat (3) @(negedge clk);
        gl_reset = 1'b0;
        check_idle(4, "reset_release");
    endtask

    task automatic test_frame_a5();
        send(8'hA5, "a5");
        check_frame(8'hA5, 0, 8'h00, "a5");
        check_idle(4, "a5_after");
    endtask

    // Receiver model samples mid-bit and rebuilds the byte.
    task automatic test_loopback();
        logic [7:0] rx;
        logic       start_bit;
        logic       stop_bit;
        int         dcount;
        rx        = 8'h00;
        start_bit = 1'b1;
        stop_bit  = 1'b0;
        dcount    = 0;
        send(8'h3C, "loop");
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
            if ((k % CPB) == (CPB / 2)) begin
                if (k / CPB == 0) start_bit = dOut;
                else if (k / CPB <= DB) rx[k / CPB - 1] = dOut;
                else stop_bit = dOut;
            end
        end
        compares++;
        if (rx !== 8'h3C) begin
            errors++;
            $display("FAIL loop_data: got %h want 3c", rx);
        end
        compares++;
        if ({start_bit, stop_bit} !== 2'b01) begin
            errors++;
            $display("FAIL loop_framing: got start/stop=%b want 01", {start_bit, stop_bit});
        end
        compares++;
        if (dcount != 1) begin
            errors++;
            $display("FAIL loop_done_count: got %0d want 1", dcount);
        end
        check_idle(3, "loop_after");
    endtask

`ifdef UAT_TX_HOLD_BUF_EN
    task automatic test_back_to_back();
        send(8'h11, "b2b");
        check_frame(8'h11, 20, 8'h22, "b2b_first");
        check_frame(8'h22, 0, 8'h00, "b2b_second");
        check_idle(10, "b2b_after");
    endtask
`else
    task automatic test_drop_while_busy();
        send(8'h11, "drop");
        check_frame(8'h11, 20, 8'h22, "drop");
        check_idle(20, "drop_after");
    endtask

    task automatic test_load_held();
        @(negedge clk);
        dIn  = 8'h96;
        load = 1'b1;
        @(posedge clk);
        #1;
        check_frame(8'h96, 0, 8'h00, "held");
        @(negedge clk);
        compares++;
        if ({dOut, busy, ready} !== 3'b101) begin
            errors++;
            $display("FAIL held_idle_visit: got dOut/busy/ready=%b want 101", {dOut, busy, ready});
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        compares++;
        if ({dOut, busy, ready} !== 3'b010) begin
            errors++;
            $display("FAIL held_second_start: got dOut/busy/ready=%b want 010", {dOut, busy, ready});
        end
        for (int n = 0; n < 200 && busy === 1'b1; n++) @(negedge clk);
        compares++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_finish: got busy=%b want 0 (timeout)", busy);
        end
        check_idle(10, "held_after");
    endtask
`endif

    task automatic test_reset_mid_frame();
        send(8'h5A, "midrst");
        repeat (30) @(negedge clk);
        #2;
        gl_reset = 1'b1;
        #1;
        compares++;
        if ({dOut, busy, ready, done} !== 4'b1010) begin
            errors++;
            $display("FAIL midrst_async: got dOut/busy/ready/done=%b want 1010",
                     {dOut, busy, ready, done});
        end
        @(negedge clk);
        gl_reset = 1'b0;
        check_idle(100, "midrst_after");
    endtask

    task automatic test_extremes();
        send(8'h00, "zeros");
        check_frame(8'h00, 0, 8'h00, "zeros");
        send(8'hFF, "ones");
        check_frame(8'hFF, 0, 8'h00, "ones");
        check_idle(4, "ones_after");
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_loopback();
`ifdef UAT_TX_HOLD_BUF_EN
        test_back_to_back();
`else
        test_drop_while_busy();
        test_load_held();
`endif
        test_reset_mid_frame();
        test_extremes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
